// File: rtl/conv_pkg.sv
// conv_pkg: shared window-scheduler state type and default geometry
package conv_pkg;
  localparam int K_H_DEF = 3;
  localparam int K_W_DEF = 3;
  localparam int DIM_W_DEF = 8;
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, LOAD, EMIT, DONE} state_t;
endpackage

// File: rtl/win_sched.sv
// win_sched: sliding-window fetch/emit scheduler over an img_w x img_h frame
module win_sched
  import conv_pkg::*;
#(
  parameter int K_H = K_H_DEF,
  parameter int K_W = K_W_DEF,
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] img_w,
  input  logic [DIM_W-1:0] img_h,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             rd_en,
  output logic [DIM_W-1:0] rd_row,
  output logic [DIM_W-1:0] rd_col,
  output logic             win_clear,
  output logic             win_load,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [DIM_W-1:0] win_row,
  output logic [DIM_W-1:0] win_col
);
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);
  localparam logic [DIM_W-1:0] KW = DIM_W'(K_W);
  localparam logic [DIM_W-1:0] KH = DIM_W'(K_H);
  localparam logic [DIM_W-1:0] KW1 = DIM_W'(K_W - 1);
  state_t state, nxt;
  logic [DIM_W-1:0] row, col, nrow, ncol, w, h;
  logic nerr;
  always_comb begin
    nxt = state;
    nrow = row;
    ncol = col;
    nerr = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (img_w >= KW && img_h >= KH) begin
          nxt = CLEAR;
          nrow = '0;
        end else nerr = 1'b1;
      end
      CLEAR: begin
        ncol = '0;
        nxt = FETCH;
      end
      FETCH: nxt = LOAD;
      LOAD: if (col < KW1) begin
        ncol = col + ONE;
        nxt = FETCH;
      end else nxt = EMIT;
      EMIT: if (win_ready) begin
        if (col < w - ONE) begin
          ncol = col + ONE;
          nxt = FETCH;
        end else if (row < h - KH) begin
          nrow = row + ONE;
          nxt = CLEAR;
        end else nxt = DONE;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) begin
      nxt = IDLE;
      nerr = 1'b0;
    end
  end
  // outputs are registered from the next state so they line up with state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      w <= '0;
      h <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      rd_en <= 1'b0;
      rd_row <= '0;
      rd_col <= '0;
      win_clear <= 1'b0;
      win_load <= 1'b0;
      win_valid <= 1'b0;
      win_row <= '0;
      win_col <= '0;
    end else begin
      if (state == IDLE && nxt == CLEAR) begin
        w <= img_w;
        h <= img_h;
      end
      state <= nxt;
      row <= nrow;
      col <= ncol;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      err <= nerr;
      rd_en <= nxt == FETCH;
      rd_row <= nxt == FETCH ? nrow : '0;
      rd_col <= nxt == FETCH ? ncol : '0;
      win_clear <= nxt == CLEAR;
      win_load <= nxt == LOAD;
      win_valid <= nxt == EMIT;
      win_row <= nxt == EMIT ? nrow : '0;
      win_col <= nxt == EMIT ? ncol - KW1 : '0;
    end
  end
endmodule

// File: tb/tb_win_sched.sv
// tb_win_sched: randomized scoreboard bench for win_sched
module tb_win_sched;
  localparam int KH = 3, KW = 3, DW = 8, LIM = 20000;
  logic clk = 0, rst = 1, start = 0, abort = 0, win_ready = 1;
  logic [DW-1:0] img_w = 0, img_h = 0;
  logic busy, done, err, rd_en, win_clear, win_load, win_valid;
  logic [DW-1:0] rd_row, rd_col, win_row, win_col;
  int tests = 0, fails = 0, cyc = 0, t0 = 0, last_hs = 0;
  int rd_cnt = 0, clr_cnt = 0, done_cnt = 0, stall_cnt = 0, last_row = 0;
  int ready_mode = 0, stall_left = 0;
  bit first_pend = 0, prev_v = 0, prev_r = 0;
  int prev_pos = 0;
  int exp_q[$];

  win_sched #(.K_H(KH), .K_W(KW), .DIM_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .img_w(img_w), .img_h(img_h),
    .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
    .win_clear(win_clear), .win_load(win_load), .win_valid(win_valid), .win_ready(win_ready),
    .win_row(win_row), .win_col(win_col)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int outs();
    return int'({busy, done, err, rd_en, win_clear, win_load, win_valid, rd_row, rd_col, win_row, win_col});
  endfunction

  initial forever begin
    @(posedge clk); #1;
    if (ready_mode == 1) win_ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 2 && win_valid && stall_left > 0) begin
      win_ready = 0;
      stall_left--;
    end else win_ready = ready_mode != 3;
  end

  always @(negedge clk) begin
    if (rst || abort) prev_v = 0;
    else begin
      if (rd_en) begin
        rd_cnt++;
        last_row = int'(rd_row);
      end
      if (win_clear) clr_cnt++;
      if (done) begin
        done_cnt++;
        chk("done_after_last_hs", cyc - last_hs, 1);
      end
      if (rd_en || win_clear || win_load || win_valid || done || err)
        chk("strobe_onehot", $countones({rd_en, win_clear, win_load, win_valid, done, err}), 1);
      if (prev_v && !prev_r) begin
        chk("stall_valid_held", int'(win_valid), 1);
        chk("stall_pos_held", int'(win_row) * 256 + int'(win_col), prev_pos);
        chk("stall_no_rd", int'(rd_en), 0);
      end
      if (win_valid && !win_ready) stall_cnt++;
      if (win_valid && first_pend) begin
        chk("first_valid_latency", cyc - t0, 2 + 2 * KW);
        first_pend = 0;
      end
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) chk("unexpected_window", int'(win_row) * 256 + int'(win_col), -1);
        else chk("window_origin", int'(win_row) * 256 + int'(win_col), exp_q.pop_front());
        last_hs = cyc;
      end
      prev_v = win_valid;
      prev_r = win_ready;
      prev_pos = int'(win_row) * 256 + int'(win_col);
    end
  end

  task automatic launch(int w, int h, int mode);
    ready_mode = mode;
    img_w = DW'(w);
    img_h = DW'(h);
    for (int r = 0; r <= h - KH; r++)
      for (int c = 0; c <= w - KW; c++) exp_q.push_back(r * 256 + c);
    rd_cnt = 0;
    clr_cnt = 0;
    stall_cnt = 0;
    start = 1;
    t0 = cyc;
    first_pend = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic run_frame(int w, int h, int mode);
    int n = 0, d0;
    d0 = done_cnt;
    launch(w, h, mode);
    img_w = DW'($urandom);
    img_h = DW'($urandom);
    while (!done && n < LIM) begin
      @(posedge clk); #1;
      n++;
      start = n == 3;
    end
    start = 0;
    chk("frame_done_seen", int'(done), 1);
    @(posedge clk); #1;
    chk("windows_left", exp_q.size(), 0);
    chk("rd_en_count", rd_cnt, (h - KH + 1) * w);
    chk("clear_count", clr_cnt, h - KH + 1);
    chk("done_count", done_cnt, d0 + 1);
    chk("idle_after_done", int'(busy), 0);
    exp_q.delete();
  endtask

  task automatic bad_start(int w, int h);
    rd_cnt = 0;
    img_w = DW'(w);
    img_h = DW'(h);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("err_pulse", int'(err), 1);
    chk("err_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("err_one_cycle", int'(err), 0);
    chk("err_no_rd", rd_cnt, 0);
  endtask

  initial begin
    int n, d0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 0);
    rst = 0;
    @(posedge clk); #1;
    run_frame(5, 3, 0);
    run_frame(4, 4, 0);
    stall_left = 5;
    launch(5, 4, 2);
    n = 0;
    while (!done && n < LIM) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    chk("stall_cycles", stall_cnt, 5);
    chk("stall_frame_windows", exp_q.size(), 0);
    run_frame(KW, KH, 1);
    run_frame(255, 3, 0);
    for (int i = 0; i < 6; i++) run_frame($urandom_range(3, 9), $urandom_range(3, 6), 1);
    bad_start(2, 5);
    bad_start(6, 2);
    abort = 1;
    start = 1;
    img_w = 5;
    img_h = 5;
    @(posedge clk); #1;
    abort = 0;
    start = 0;
    chk("abort_beats_start", int'(busy), 0);
    // abort during a LOAD of row 1
    d0 = done_cnt;
    launch(6, 5, 0);
    n = 0;
    while (!(win_load && last_row == 1) && n < LIM) begin @(posedge clk); #1; n++; end
    chk("reached_row1_load", int'(win_load), 1);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_outputs", outs(), 0);
    exp_q.delete();
    first_pend = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);
    chk("abort_idle", int'(busy), 0);
    run_frame(6, 5, 1);
    // reset while stalled in EMIT
    launch(5, 4, 3);
    n = 0;
    while (!win_valid && n < LIM) begin @(posedge clk); #1; n++; end
    chk("reached_emit", int'(win_valid), 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk("rst_outputs", outs(), 0);
    rst = 0;
    exp_q.delete();
    first_pend = 0;
    @(posedge clk); #1;
    chk("rst_quiet", outs(), 0);
    run_frame(7, 4, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
